// File: rtl/display_scan_controller.sv
// Multiplexed scan controller for a 4-digit common-anode 7-segment display with a double-buffered value.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading zero digits dark; digit 0 is always lit.
module display_scan_controller #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Enable,
  input  logic        i_Load,
  input  logic [15:0] i_Value,
  output logic [3:0]  o_Nibble,
  output logic [3:0]  o_Anodes,
  output logic        o_Frame,
  output logic        o_Pending
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic [3:0]    lit;

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
    nib = v[{i, 2'b00} +: 4];
  endfunction

  // Anode pattern for the SHOW phase of the current digit.
  always_comb begin
    lit      = 4'b1111;
    lit[idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    if (active[15:12] == 4'h0) lit = 4'b1111;
      2'd2:    if (active[15:8] == 8'h00) lit = 4'b1111;
      2'd1:    if (active[15:4] == 12'h000) lit = 4'b1111;
      default: ;
    endcase
`endif
  end

  // i_Load is a fire-and-forget strobe: no ready, every asserted cycle is
  // captured into the shadow, and the most recent capture wins.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= BLANK;
      cnt       <= '0;
      idx       <= 2'd0;
      active    <= 16'h0000;
      shadow    <= 16'h0000;
      o_Nibble  <= 4'h0;
      o_Anodes  <= 4'b1111;
      o_Frame   <= 1'b0;
      o_Pending <= 1'b0;
    end else begin
      o_Frame <= 1'b0;
      if (!i_Enable) begin
        state    <= BLANK;
        cnt      <= '0;
        idx      <= 2'd0;
        o_Anodes <= 4'b1111;
        o_Nibble <= active[3:0];
      end else if (cnt == LAST_CNT) begin
        state    <= BLANK;
        cnt      <= '0;
        idx      <= idx + 2'd1;
        o_Anodes <= 4'b1111;
        if (idx == 2'd3) begin
          o_Frame <= 1'b1;
          // Swap buffers only at the frame boundary so a frame never mixes two values.
          if (o_Pending) begin
            active    <= shadow;
            o_Nibble  <= shadow[3:0];
            o_Pending <= 1'b0;
          end else begin
            o_Nibble <= active[3:0];
          end
        end else begin
          o_Nibble <= nib(active, idx + 2'd1);
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (state == BLANK && cnt == BLANK_END) begin
          state    <= SHOW;
          o_Anodes <= lit;
        end
      end
      if (i_Load) begin
        shadow    <= i_Value;
        o_Pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with SCAN_DIV=8, BLANK_CYCLES=2.
// Honours LEADING_ZERO_BLANK_EN in its anode model when the macro is defined.
module tb_display_scan_controller;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  nibble;
  logic [3:0]  anodes;
  logic        frame;
  logic        pending;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .i_Enable (en),
    .i_Load   (load),
    .i_Value  (value),
    .o_Nibble (nibble),
    .o_Anodes (anodes),
    .o_Frame  (frame),
    .o_Pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_an(input logic [15:0] v, input int d);
    logic [3:0] a;
    a    = 4'b1111;
    a[d] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0000) a = 4'b1111;
`endif
    return a;
  endfunction

  // Walks one full frame starting at slot cycle 0 of digit 0; optional loads at frame cycles la/lb.
  task automatic check_frame(input logic [15:0] val, input int la, input logic [15:0] lav,
                             input int lb, input logic [15:0] lbv);
    for (int d = 0; d < 4; d++) exp_q.push_back(val[4*d +: 4]);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      for (int s = 0; s < SD; s++) begin
        int c;
        c = d * SD + s;
        check("nibble", nibble, e);
        check("anodes", anodes, (s < BC) ? 4'b1111 : exp_an(val, d));
        if (c > 0) check("frame_low", frame, 1'b0);
        if (la >= 0 && c == la + 1) check("pending_set", pending, 1'b1);
        if (c == la) begin load = 1'b1; value = lav; end
        if (c == lb) begin load = 1'b1; value = lbv; end
        tick();
        load = 1'b0;
      end
    end
    check("frame_pulse", frame, 1'b1);
  endtask

  initial begin
    #12;
    check("rst_anodes", anodes, 4'b1111);
    check("rst_nibble", nibble, 4'h0);
    check("rst_frame", frame, 1'b0);
    check("rst_pending", pending, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Load during first frame, shown from the second frame.
    check_frame(16'h0000, 3, 16'h1234, -1, 16'h0);
    check("wrap1_pending", pending, 1'b0);
    check_frame(16'h1234, 5, 16'h5678, 31, 16'hABCD);
    check("wrap_load_pending", pending, 1'b1);
    check_frame(16'h5678, -1, 16'h0, -1, 16'h0);
    check("abcd_pending", pending, 1'b0);
    check_frame(16'hABCD, -1, 16'h0, -1, 16'h0);

    // Disable mid-SHOW of digit 2.
    for (int i = 0; i < 20; i++) tick();
    check("pre_disable_anodes", anodes, 4'b1011);
    en = 1'b0;
    tick();
    check("dis_anodes", anodes, 4'b1111);
    check("dis_nibble", nibble, 4'hD);
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin load = 1'b1; value = 16'h9000; end
      tick();
      load = 1'b0;
      check("dis_anodes_hold", anodes, 4'b1111);
      check("dis_frame", frame, 1'b0);
    end
    check("dis_pending", pending, 1'b1);
    en = 1'b1;
    check_frame(16'hABCD, -1, 16'h0, -1, 16'h0);
    check("reen_pending", pending, 1'b0);
    check_frame(16'h9000, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset mid-SHOW with a pending value.
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin load = 1'b1; value = 16'h4321; end
      tick();
      load = 1'b0;
    end
    check("pre_rst_pending", pending, 1'b1);
    check("pre_rst_anodes", anodes, 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_anodes", anodes, 4'b1111);
    check("async_pending", pending, 1'b0);
    check("async_nibble", nibble, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, 3, 16'h0040, -1, 16'h0);
    check_frame(16'h0040, 3, 16'h0000, -1, 16'h0);
    check_frame(16'h0000, 3, 16'hF00F, -1, 16'h0);
    check_frame(16'hF00F, -1, 16'h0, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
